// File: rtl/cp0_exc_unit_pkg.sv
// Shared CP0 register numbers and exception codes for the CP0 unit and ECMUX stages.
// The optional BadVAddr register (reg 8) is built only when CP0_BADVADDR_EN is defined.
package cp0_exc_unit_pkg;

  localparam int unsigned CP0_ADDR_W = 5;
  localparam int unsigned EXC_CODE_W = 5;
  localparam int unsigned HWINT_W    = 6;

  // CP0 register numbers
  localparam logic [CP0_ADDR_W-1:0] REG_BADVADDR = 5'd8;
  localparam logic [CP0_ADDR_W-1:0] REG_SR       = 5'd12;
  localparam logic [CP0_ADDR_W-1:0] REG_CAUSE    = 5'd13;
  localparam logic [CP0_ADDR_W-1:0] REG_EPC      = 5'd14;

  // Exception codes; No_ExcCode sits outside every architectural code
  localparam logic [EXC_CODE_W-1:0] EXC_INT     = 5'd0;
  localparam logic [EXC_CODE_W-1:0] EXC_ADEL    = 5'd4;
  localparam logic [EXC_CODE_W-1:0] EXC_ADES    = 5'd5;
  localparam logic [EXC_CODE_W-1:0] EXC_SYSCALL = 5'd8;
  localparam logic [EXC_CODE_W-1:0] EXC_RI      = 5'd10;
  localparam logic [EXC_CODE_W-1:0] EXC_OV      = 5'd12;
  localparam logic [EXC_CODE_W-1:0] NO_EXC_CODE = 5'd31;

  function automatic logic is_addr_exc(input logic [EXC_CODE_W-1:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_exc_unit.sv
// CP0 exception unit: SR/Cause/EPC registers, interrupt/exception request and mtc0/mfc0 access.
// Define CP0_BADVADDR_EN to add the VAddr input and the read-only BadVAddr register.
module cp0_exc_unit
  import cp0_exc_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  CP0Add,
  input  logic [31:0] CP0In,
  output logic [31:0] CP0Out,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
`ifdef CP0_BADVADDR_EN
  input  logic [31:0] VAddr,
`endif
  output logic [31:0] EPCOut,
  output logic        Req
);

  logic [HWINT_W-1:0]    im;
  logic                  exl;
  logic                  ie;
  logic                  bd;
  logic [HWINT_W-1:0]    ip;
  logic [EXC_CODE_W-1:0] exc_code;
  logic [31:0]           epc;
  logic                  int_req;
  logic                  exc_req;
  logic                  mtc0_wr;
`ifdef CP0_BADVADDR_EN
  logic [31:0]           badvaddr;
`endif

  assign int_req = (|(HWInt & im)) & ie & ~exl;
  assign exc_req = (ExcCodeIn != NO_EXC_CODE) & ~exl;
  assign Req     = int_req | exc_req;
  assign mtc0_wr = en & ~Req;
  assign EPCOut  = epc;

  // Register update; a taken request overrides both mtc0 and eret
  always_ff @(posedge clk) begin
    if (reset) begin
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip       <= '0;
      exc_code <= '0;
      epc      <= '0;
`ifdef CP0_BADVADDR_EN
      badvaddr <= '0;
`endif
    end else begin
      ip <= HWInt;
      if (Req) begin
        exl      <= 1'b1;
        bd       <= BDIn;
        epc      <= BDIn ? (VPC - 32'd4) : VPC;
        exc_code <= int_req ? EXC_INT : ExcCodeIn;
`ifdef CP0_BADVADDR_EN
        if (!int_req && is_addr_exc(ExcCodeIn)) begin
          badvaddr <= VAddr;
        end
`endif
      end else begin
        if (EXLClr) begin
          exl <= 1'b0;
        end
        if (mtc0_wr && (CP0Add == REG_SR)) begin
          im  <= CP0In[15:10];
          exl <= CP0In[1];
          ie  <= CP0In[0];
        end
        if (mtc0_wr && (CP0Add == REG_EPC)) begin
          epc <= CP0In;
        end
      end
    end
  end

  // mfc0 read mux; unimplemented numbers read as zero
  always_comb begin
    CP0Out = '0;
    case (CP0Add)
      REG_SR:    CP0Out = {16'b0, im, 8'b0, exl, ie};
      REG_CAUSE: CP0Out = {bd, 15'b0, ip, 3'b0, exc_code, 2'b0};
      REG_EPC:   CP0Out = epc;
`ifdef CP0_BADVADDR_EN
      REG_BADVADDR: CP0Out = badvaddr;
`endif
      default:   CP0Out = '0;
    endcase
  end

endmodule
